drr_input_scheduler: RTL and testbench
======================================

# drr_input_scheduler

Deficit-round-robin grant scheduler for the NUM_QUEUES rx-queue FIFOs that feed the datapath's single output port. It replaces plain per-packet round-robin, so queues carrying small packets no longer get less bandwidth than queues carrying large ones. It decides only which queue sends next; the datapath mux/FSM moves the words and reports each end-of-packet back. Per-queue quanta come from a simple write port driven by the register block.

## Interface
Parameters:
- NUM_QUEUES, 8, number of requesters; power of two.
- LEN_WIDTH, 16, width of the head-packet byte-length field.
- QUANTUM_WIDTH, 16, width of each per-queue quantum.
- DEFICIT_WIDTH, 18, deficit counter width; must be at least max(LEN_WIDTH, QUANTUM_WIDTH)+1.
- DEFAULT_QUANTUM, 1536, quantum loaded into every queue at reset.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- req  in  NUM_QUEUES  bit i=1: queue i holds a complete packet at its head.
- pkt_len  in  NUM_QUEUES*LEN_WIDTH  head-packet byte length, queue i in bits [i*LEN_WIDTH +: LEN_WIDTH]; valid only while req[i]=1.
- quantum_wr_en  in  1  writes one quantum.
- quantum_wr_addr  in  log2(NUM_QUEUES)  target queue for the write.
- quantum_wr_data  in  QUANTUM_WIDTH  new quantum value.
- grant_valid  out  1  registered; 1 = grant_queue owns the output until pkt_done.
- grant_queue  out  log2(NUM_QUEUES)  registered index of the granted queue.
- pkt_done  in  1  one-cycle pulse from the datapath when the granted packet's EOP word is written.

## Operation
- State: cur (queue pointer), deficit[NUM_QUEUES], quantum[NUM_QUEUES], FSM {VISIT, SERVE, WAIT_DONE}.
- VISIT:
  - If req[cur]=0: clear deficit[cur], set cur to cur+1 (wrapping at NUM_QUEUES-1 to 0), stay in VISIT.
  - Otherwise: deficit[cur] <= sat(deficit[cur] + quantum[cur]), then go to SERVE.
- SERVE: define len = max(pkt_len[cur], 1); a length of 0 is charged as 1.
  - If req[cur]=1 and len <= deficit[cur]:
    - deficit[cur] <= deficit[cur] - len
    - grant_valid <= 1, grant_queue <= cur
    - go to WAIT_DONE
  - Else if req[cur]=0: clear deficit[cur], advance cur, go to VISIT.
  - Else (packet too large): keep deficit[cur], advance cur, go to VISIT.
- WAIT_DONE: hold grant_valid and grant_queue. On pkt_done: grant_valid <= 0, go to SERVE on the same queue so it can send further packets within its remaining deficit.
- pkt_done outside WAIT_DONE is ignored.
- Arithmetic:
  - Deficit addition saturates at 2^DEFICIT_WIDTH-1.
  - Subtraction cannot underflow, because it is only taken when len <= deficit.
  - pkt_len is zero-extended to DEFICIT_WIDTH.
- Quantum writes:
  - Take effect at the next VISIT of that queue; the current deficit is unchanged.
  - quantum=0 means the queue is served only from credit it already holds; it never gains new credit.
- req or pkt_len of a non-current queue changing has no effect until that queue is visited.

## Timing
- Reset values: grant_valid=0, grant_queue=0, cur=0, state=VISIT, all deficits 0, all quanta DEFAULT_QUANTUM.
- Reset asserted mid-packet returns every value above to its reset value at that edge. Any in-flight grant is dropped; the datapath is reset by the same reset.
- Grant latency: with req[cur]=1 and sufficient quantum, grant_valid=1 two clock edges after entering VISIT (VISIT edge, then SERVE edge).
- Back-to-back packets from one queue: grant_valid low for exactly one cycle after pkt_done (WAIT_DONE -> SERVE -> grant).
- Skipping an empty queue costs 1 cycle. Skipping a queue whose packet is too large costs 2 cycles (VISIT + SERVE).
- pkt_done in the same cycle as reset: reset wins.
- A quantum write in the same cycle as the VISIT of that queue: the old quantum is used.

## Structure
- Shared package (in_arb_pkg):
  - FSM state encoding.
  - log2 function.
  - DEFAULT_QUANTUM.
  - DEFICIT_WIDTH derivation rule.
- One natural sub-module, drr_quantum_regs:
  - Flop array of NUM_QUEUES quanta with the write port.
  - Combinational read by cur.
  - Reset to DEFAULT_QUANTUM.
- Deficit counters and FSM stay in the top module.

## Test plan
- Single queue, quantum 1536: req[2]=1, 100-byte packets with pkt_done 5 cycles after each grant.
  - First grant 2 cycles after cur reaches 2.
  - 15 grants on queue 2 (deficit 1536 → 36 left), then cur advances.
- Fairness: queue 0 sends 64-byte packets and queue 1 sends 1500-byte packets, both always requesting, equal quanta 1536.
  - Over 10 rounds, granted bytes per queue are within one quantum of each other.
- Too-large packet: quantum 500, pkt_len 1200 on queue 3.
  - Grant on the third visit; deficit goes 500 → 1000 → 1500 → 300 after the grant.
- Empty queue: queue 4 builds deficit 400, then req[4] drops.
  - Next visit clears deficit[4] to 0; scan costs 1 cycle.
- Quantum write: write quantum[1]=64 while queue 1 is in WAIT_DONE.
  - The current deficit is unchanged; the next visit adds 64.
- Reset mid-packet: assert reset in WAIT_DONE.
  - Next cycle grant_valid=0, grant_queue=0, all deficits 0, quanta 1536.
  - pkt_done asserted in that same cycle is ignored.

Source files
------------

// File: rtl/in_arb_pkg.sv
// Shared definitions for the rx-queue input arbiter: FSM encoding, sizing helpers
// and the reset quantum.
package in_arb_pkg;

  typedef enum logic [1:0] {
    ST_VISIT     = 2'd0,
    ST_SERVE     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } drr_state_t;

  localparam int DEFAULT_QUANTUM = 1536;

  // Index width for n requesters; never below one bit.
  function automatic int log2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Smallest deficit width that holds any quantum or length plus one bit of headroom.
  function automatic int deficit_width(input int len_w, input int quantum_w);
    return ((len_w > quantum_w) ? len_w : quantum_w) + 1;
  endfunction

endpackage

// File: rtl/drr_quantum_regs.sv
// Per-queue quantum register file: one write port from the register block,
// one combinational read port addressed by the scheduler's current queue.
module drr_quantum_regs
  import in_arb_pkg::*;
#(
  parameter int NUM_QUEUES      = 8,
  parameter int QUANTUM_WIDTH   = 16,
  parameter int DEFAULT_QUANTUM = in_arb_pkg::DEFAULT_QUANTUM
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_wr_en,
  input  logic [log2(NUM_QUEUES)-1:0]   i_wr_addr,
  input  logic [QUANTUM_WIDTH-1:0]      i_wr_data,
  input  logic [log2(NUM_QUEUES)-1:0]   i_rd_addr,
  output logic [QUANTUM_WIDTH-1:0]      o_rd_data
);

  logic [QUANTUM_WIDTH-1:0] r_quantum [NUM_QUEUES];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_QUEUES; i++) r_quantum[i] <= QUANTUM_WIDTH'(DEFAULT_QUANTUM);
    end else if (i_wr_en) begin
      r_quantum[i_wr_addr] <= i_wr_data;
    end
  end

  // A write landing on the same edge as a VISIT is not seen until the next visit.
  assign o_rd_data = r_quantum[i_rd_addr];

endmodule

// File: rtl/drr_input_scheduler.sv
// Deficit-round-robin grant scheduler for the rx-queue FIFOs feeding the single
// output port; the datapath moves the words and pulses pkt_done at EOP.
module drr_input_scheduler
  import in_arb_pkg::*;
#(
  parameter int NUM_QUEUES      = 8,
  parameter int LEN_WIDTH       = 16,
  parameter int QUANTUM_WIDTH   = 16,
  parameter int DEFICIT_WIDTH   = 18,
  parameter int DEFAULT_QUANTUM = in_arb_pkg::DEFAULT_QUANTUM
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_QUEUES-1:0]           req,
  input  logic [NUM_QUEUES*LEN_WIDTH-1:0] pkt_len,
  input  logic                            quantum_wr_en,
  input  logic [log2(NUM_QUEUES)-1:0]     quantum_wr_addr,
  input  logic [QUANTUM_WIDTH-1:0]        quantum_wr_data,
  output logic                            grant_valid,
  output logic [log2(NUM_QUEUES)-1:0]     grant_queue,
  input  logic                            pkt_done
);

  localparam int AW = log2(NUM_QUEUES);
  localparam int DW = DEFICIT_WIDTH;

  function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a,
                                            input logic [QUANTUM_WIDTH-1:0] b);
    logic [DW:0] s;
    s = {1'b0, a} + (DW+1)'(b);
    return s[DW] ? {DW{1'b1}} : s[DW-1:0];
  endfunction

  // Zero-length packets are charged one byte so they cannot be granted for free forever.
  function automatic logic [DW-1:0] charge_len(input logic [LEN_WIDTH-1:0] len);
    return (len == '0) ? DW'(1) : DW'(len);
  endfunction

  drr_state_t               r_state, w_state_nxt;
  logic [AW-1:0]            r_cur, w_cur_nxt, w_cur_inc;
  logic [DW-1:0]            r_deficit [NUM_QUEUES];
  logic                     r_grant_valid;
  logic [AW-1:0]            r_grant_queue;
  logic                     w_def_we;
  logic [DW-1:0]            w_def_nxt;
  logic                     w_grant_set;
  logic                     w_grant_clr;
  logic [QUANTUM_WIDTH-1:0] w_quantum;
  logic [LEN_WIDTH-1:0]     w_len_arr [NUM_QUEUES];
  logic [DW-1:0]            w_len;
  logic [DW-1:0]            w_def_cur;
  logic                     w_req_cur;

  always_comb begin
    for (int i = 0; i < NUM_QUEUES; i++) w_len_arr[i] = pkt_len[i*LEN_WIDTH +: LEN_WIDTH];
  end

  assign w_req_cur = req[r_cur];
  assign w_def_cur = r_deficit[r_cur];
  assign w_len     = charge_len(w_len_arr[r_cur]);
  assign w_cur_inc = r_cur + 1'b1;

  drr_quantum_regs #(
    .NUM_QUEUES      (NUM_QUEUES),
    .QUANTUM_WIDTH   (QUANTUM_WIDTH),
    .DEFAULT_QUANTUM (DEFAULT_QUANTUM)
  ) u_quantum (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_wr_en   (quantum_wr_en),
    .i_wr_addr (quantum_wr_addr),
    .i_wr_data (quantum_wr_data),
    .i_rd_addr (r_cur),
    .o_rd_data (w_quantum)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_def_we    = 1'b0;
    w_def_nxt   = w_def_cur;
    w_grant_set = 1'b0;
    w_grant_clr = 1'b0;
    case (r_state)
      ST_VISIT: begin
        w_def_we = 1'b1;
        if (!w_req_cur) begin
          w_def_nxt = '0;
          w_cur_nxt = w_cur_inc;
        end else begin
          w_def_nxt   = sat_add(w_def_cur, w_quantum);
          w_state_nxt = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (w_req_cur && (w_len <= w_def_cur)) begin
          w_def_we    = 1'b1;
          w_def_nxt   = w_def_cur - w_len;
          w_grant_set = 1'b1;
          w_state_nxt = ST_WAIT_DONE;
        end else begin
          // An emptied queue forfeits its credit; a blocked one keeps it for next round.
          w_def_we    = !w_req_cur;
          w_def_nxt   = '0;
          w_cur_nxt   = w_cur_inc;
          w_state_nxt = ST_VISIT;
        end
      end
      ST_WAIT_DONE: begin
        if (pkt_done) begin
          w_grant_clr = 1'b1;
          w_state_nxt = ST_SERVE;
        end
      end
      default: w_state_nxt = ST_VISIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_VISIT;
      r_cur         <= '0;
      r_grant_valid <= 1'b0;
      r_grant_queue <= '0;
      for (int i = 0; i < NUM_QUEUES; i++) r_deficit[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cur   <= w_cur_nxt;
      if (w_def_we) r_deficit[r_cur] <= w_def_nxt;
      if (w_grant_set) begin
        r_grant_valid <= 1'b1;
        r_grant_queue <= r_cur;
      end else if (w_grant_clr) begin
        r_grant_valid <= 1'b0;
      end
    end
  end

  assign grant_valid = r_grant_valid;
  assign grant_queue = r_grant_queue;

endmodule

// File: tb/tb_drr_input_scheduler.sv
// Scoreboard bench for drr_input_scheduler: each scenario queues the expected
// (queue, cycle) grants; a monitor pops and compares them as grants appear.
module tb_drr_input_scheduler;

  localparam int NQ = 8;
  localparam int LW = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NQ-1:0]     req;
  logic [NQ*LW-1:0]  pkt_len;
  logic              quantum_wr_en;
  logic [2:0]        quantum_wr_addr;
  logic [15:0]       quantum_wr_data;
  logic              grant_valid;
  logic [2:0]        grant_queue;
  logic              pkt_done;

  typedef struct {
    int q;
    int k;
  } exp_t;

  exp_t   sb[$];
  exp_t   e_mon;
  int     cyc = 0;
  int     t0;
  int     total;
  int     bad;
  int     resp_en;
  int     hold_cnt;
  int     lens[NQ];
  longint bytes[NQ];
  logic   prev_gv;

  drr_input_scheduler dut (
    .clk             (clk),
    .reset           (reset),
    .req             (req),
    .pkt_len         (pkt_len),
    .quantum_wr_en   (quantum_wr_en),
    .quantum_wr_addr (quantum_wr_addr),
    .quantum_wr_data (quantum_wr_data),
    .grant_valid     (grant_valid),
    .grant_queue     (grant_queue),
    .pkt_done        (pkt_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic set_len(input int q, input int len);
    lens[q] = len;
    pkt_len[q*LW +: LW] = LW'(len);
  endtask

  task automatic expect_grant(input int q, input int k);
    exp_t e;
    e.q = q;
    e.k = k;
    sb.push_back(e);
  endtask

  // Cycle k = number of edges since reset release, counted from 0.
  task automatic wait_k(input int n);
    int lim = 0;
    while (((cyc - t0 - 1) < n) && (lim < 5000)) begin
      @(negedge clk);
      lim++;
    end
  endtask

  task automatic drain(input string tag, input int limit);
    int n = 0;
    while ((sb.size() != 0) && (n < limit)) begin
      @(negedge clk);
      n++;
    end
    chk(tag, sb.size(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    pkt_len = '0;
    quantum_wr_en = 1'b0;
    resp_en = 1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    t0 = cyc;
    sb.delete();
    for (int i = 0; i < NQ; i++) bytes[i] = 0;
  endtask

  task automatic write_q(input int q, input int val);
    quantum_wr_en = 1'b1;
    quantum_wr_addr = 3'(q);
    quantum_wr_data = 16'(val);
    @(negedge clk);
    quantum_wr_en = 1'b0;
  endtask

  // Queue 2 alone, 100-byte packets, quantum 1536: 15 grants, 36 left, then one full scan.
  task automatic push_series_a();
    for (int i = 0; i < 15; i++) expect_grant(2, 3 + 6 * i);
    expect_grant(2, 102);
  endtask

  always @(negedge clk) begin
    if (grant_valid && !prev_gv) begin
      if (sb.size() == 0) begin
        chk("unexpected_grant_queue", grant_queue, -1);
      end else begin
        e_mon = sb.pop_front();
        chk("grant_queue", grant_queue, e_mon.q);
        if (e_mon.k >= 0) chk("grant_cycle", cyc - t0 - 1, e_mon.k);
      end
      bytes[grant_queue] += lens[grant_queue];
    end
    prev_gv = grant_valid;
  end

  // Datapath stand-in: pkt_done is seen by the DUT five edges after each grant.
  initial begin
    hold_cnt = 0;
    forever begin
      @(negedge clk);
      if (!grant_valid) begin
        hold_cnt = 0;
        if (resp_en != 0) pkt_done = 1'b0;
      end else if ((resp_en != 0) && !pkt_done) begin
        hold_cnt++;
        if (hold_cnt == 5) begin
          pkt_done = 1'b1;
          hold_cnt = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    longint diff;
    total = 0;
    bad = 0;
    resp_en = 1;
    pkt_done = 1'b0;
    req = '0;
    pkt_len = '0;
    quantum_wr_en = 1'b0;
    quantum_wr_addr = '0;
    quantum_wr_data = '0;
    t0 = 0;
    prev_gv = 1'b0;
    for (int i = 0; i < NQ; i++) begin
      lens[i] = 0;
      bytes[i] = 0;
    end

    repeat (3) @(negedge clk);
    chk("rst_grant_valid", grant_valid, 0);
    chk("rst_grant_queue", grant_queue, 0);

    do_reset();
    set_len(2, 100);
    req = 8'h04;
    push_series_a();
    drain("single_queue_drain", 200);

    do_reset();
    set_len(0, 64);
    set_len(1, 1500);
    req = 8'h03;
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 24; i++) expect_grant(0, -1);
      expect_grant(1, -1);
    end
    drain("fair_drain", 2500);
    chk("fair_bytes_q0", bytes[0], 15360);
    chk("fair_bytes_q1", bytes[1], 15000);
    diff = (bytes[0] > bytes[1]) ? bytes[0] - bytes[1] : bytes[1] - bytes[0];
    chk("fair_within_quantum", (diff <= 1536) ? 1 : 0, 1);

    do_reset();
    set_len(3, 1200);
    req = 8'h08;
    write_q(3, 500);
    expect_grant(3, 22);
    expect_grant(3, 46);
    drain("too_large_drain", 200);

    do_reset();
    set_len(4, 500);
    req = 8'h10;
    write_q(4, 400);
    expect_grant(4, 31);
    wait_k(8);
    req = 8'h00;
    wait_k(16);
    req = 8'h10;
    drain("empty_clear_drain", 200);

    do_reset();
    set_len(5, 0);
    req = 8'h20;
    write_q(5, 3);
    expect_grant(5, 6);
    expect_grant(5, 12);
    expect_grant(5, 18);
    expect_grant(5, 33);
    drain("zero_len_drain", 200);

    do_reset();
    set_len(1, 1000);
    req = 8'h02;
    expect_grant(1, 2);
    expect_grant(1, 80);
    wait_k(3);
    write_q(1, 64);
    drain("quantum_write_drain", 200);

    do_reset();
    set_len(2, 100);
    req = 8'h04;
    expect_grant(2, 3);
    wait_k(3);
    write_q(2, 100);
    wait_k(5);
    chk("pre_reset_grant_valid", grant_valid, 1);
    resp_en = 0;
    pkt_done = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    chk("midpkt_reset_grant_valid", grant_valid, 0);
    chk("midpkt_reset_grant_queue", grant_queue, 0);
    chk("midpkt_reset_pending", sb.size(), 0);
    pkt_done = 1'b0;
    reset = 1'b0;
    t0 = cyc;
    resp_en = 1;
    push_series_a();
    drain("after_reset_drain", 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
